// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART framing blocks (the transmit framer here,
//   and the receive-side deframer that will reuse the same constants).
//   - frame_state_t : state encoding of the transmit framer FSM
//   - DEF_*         : default delimiter / escape constants
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_BYTE = 3'd2,
        ST_ESC  = 3'd3,
        ST_WAIT = 3'd4,
        ST_CKS  = 3'd5,
        ST_EOF  = 3'd6
    } frame_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'h7E;
    localparam logic [7:0] DEF_ESC_BYTE  = 8'h7D;
    localparam logic [7:0] DEF_ESC_XOR   = 8'h20;

endpackage

// File: rtl/uart_frame_esc.sv
// uart_frame_esc
//   Combinational escape decision for one byte. A byte that collides with the
//   frame delimiter or the escape prefix must be sent as ESC_BYTE followed by
//   the byte XORed with ESC_XOR.
//   Ports:
//     i_byte     in  WIDTH : candidate byte
//     o_need_esc out 1     : byte must be escaped
//     o_esc_val  out WIDTH : second byte of the escaped pair
module uart_frame_esc
    import uart_frame_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(DEF_SYNC_BYTE),
    parameter logic [WIDTH-1:0] ESC_BYTE  = WIDTH'(DEF_ESC_BYTE),
    parameter logic [WIDTH-1:0] ESC_XOR   = WIDTH'(DEF_ESC_XOR)
) (
    input  logic [WIDTH-1:0] i_byte,
    output logic             o_need_esc,
    output logic [WIDTH-1:0] o_esc_val
);

    assign o_need_esc = (i_byte == SYNC_BYTE) || (i_byte == ESC_BYTE);
    assign o_esc_val  = i_byte ^ ESC_XOR;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   HDLC-style packet framer feeding a buffered UART transmitter. Payload words
//   are split into bytes (byte 0 = s_data[WIDTH-1:0] first), byte-stuffed and
//   wrapped as SYNC, payload, [checksum], SYNC.
//   Build option: define UART_TX_FRAMER_CKSUM_EN to append the two's-complement
//   checksum of the payload bytes before the closing SYNC.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     s_data/s_valid/
//     s_last/s_ready      : payload word stream in
//     tx_din/tx_req/
//     tx_ready            : byte stream out to the transmitter FIFO
//     busy                : a frame is in progress
module uart_tx_framer
    import uart_frame_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               WORD_BYTES = 4,
    parameter logic [WIDTH-1:0] SYNC_BYTE  = WIDTH'(DEF_SYNC_BYTE),
    parameter logic [WIDTH-1:0] ESC_BYTE   = WIDTH'(DEF_ESC_BYTE),
    parameter logic [WIDTH-1:0] ESC_XOR    = WIDTH'(DEF_ESC_XOR)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH*WORD_BYTES-1:0] s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [WIDTH-1:0]            tx_din,
    output logic                        tx_req,
    input  logic                        tx_ready,
    output logic                        busy
);

    localparam int               IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

    frame_state_t                r_state, w_state_next;
    logic [IDX_W-1:0]            r_idx, w_idx_next;
    logic [WIDTH*WORD_BYTES-1:0] r_word, w_word_next;
    logic                        r_last, w_last_next;
    logic                        w_advance;

    logic [WIDTH-1:0]            w_bytes [WORD_BYTES];
    logic [WIDTH-1:0]            w_cur_byte;
    logic [WIDTH-1:0]            w_esc_in;
    logic                        w_need_esc;
    logic [WIDTH-1:0]            w_esc_val;
    logic [WIDTH-1:0]            w_din;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
            assign w_bytes[gi] = r_word[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_cur_byte = w_bytes[r_idx];

`ifdef UART_TX_FRAMER_CKSUM_EN
    logic [WIDTH-1:0] r_cks, w_cks_next;
    // Set once the payload is finished, so the shared escaper and the ESC
    // state know they are handling the checksum rather than a payload byte.
    logic             r_cks_phase, w_cks_phase_next;
    logic [WIDTH-1:0] w_cks_val;

    assign w_cks_val = -r_cks;
    assign w_esc_in  = r_cks_phase ? w_cks_val : w_cur_byte;
`else
    assign w_esc_in  = w_cur_byte;
`endif

    // Single escaper shared between payload bytes and the checksum byte.
    uart_frame_esc #(
        .WIDTH     (WIDTH),
        .SYNC_BYTE (SYNC_BYTE),
        .ESC_BYTE  (ESC_BYTE),
        .ESC_XOR   (ESC_XOR)
    ) u_esc (
        .i_byte     (w_esc_in),
        .o_need_esc (w_need_esc),
        .o_esc_val  (w_esc_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
`ifdef UART_TX_FRAMER_CKSUM_EN
            r_cks       <= '0;
            r_cks_phase <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_word  <= w_word_next;
            r_last  <= w_last_next;
`ifdef UART_TX_FRAMER_CKSUM_EN
            r_cks       <= w_cks_next;
            r_cks_phase <= w_cks_phase_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_word_next  = r_word;
        w_last_next  = r_last;
        w_advance    = 1'b0;
`ifdef UART_TX_FRAMER_CKSUM_EN
        w_cks_next       = r_cks;
        w_cks_phase_next = r_cks_phase;
`endif
        case (r_state)
            ST_IDLE: begin
                if (s_valid) begin
                    w_word_next  = s_data;
                    w_last_next  = s_last;
                    w_idx_next   = '0;
                    w_state_next = ST_SOF;
`ifdef UART_TX_FRAMER_CKSUM_EN
                    w_cks_next       = '0;
                    w_cks_phase_next = 1'b0;
`endif
                end
            end
            ST_SOF: begin
                if (tx_ready) w_state_next = ST_BYTE;
            end
            ST_BYTE: begin
                if (tx_ready) begin
                    if (w_need_esc) w_state_next = ST_ESC;
                    else            w_advance    = 1'b1;
                end
            end
            ST_ESC: begin
                if (tx_ready) begin
`ifdef UART_TX_FRAMER_CKSUM_EN
                    if (r_cks_phase) w_state_next = ST_EOF;
                    else             w_advance    = 1'b1;
`else
                    w_advance = 1'b1;
`endif
                end
            end
            ST_WAIT: begin
                if (s_valid) begin
                    w_word_next  = s_data;
                    w_last_next  = s_last;
                    w_idx_next   = '0;
                    w_state_next = ST_BYTE;
                end
            end
`ifdef UART_TX_FRAMER_CKSUM_EN
            ST_CKS: begin
                if (tx_ready) w_state_next = w_need_esc ? ST_ESC : ST_EOF;
            end
`endif
            ST_EOF: begin
                if (tx_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // A payload byte (plain or the second half of an escaped pair) has
        // been accepted: fold it into the sum and move on.
        if (w_advance) begin
`ifdef UART_TX_FRAMER_CKSUM_EN
            w_cks_next = r_cks + w_cur_byte;
`endif
            if (r_idx != IDX_LAST) begin
                w_idx_next   = r_idx + IDX_W'(1);
                w_state_next = ST_BYTE;
            end else if (r_last) begin
`ifdef UART_TX_FRAMER_CKSUM_EN
                w_cks_phase_next = 1'b1;
                w_state_next     = ST_CKS;
`else
                w_state_next = ST_EOF;
`endif
            end else begin
                w_state_next = ST_WAIT;
            end
        end
    end

    // Outputs come from registered state only (never from tx_ready), and are
    // forced quiet while reset is asserted.
    always_comb begin
        w_din = '0;
        case (r_state)
            ST_SOF, ST_EOF:  w_din = SYNC_BYTE;
            ST_BYTE, ST_CKS: w_din = w_need_esc ? ESC_BYTE : w_esc_in;
            ST_ESC:          w_din = w_esc_val;
            default:         w_din = '0;
        endcase
        tx_din  = rst ? '0 : w_din;
        tx_req  = !rst && (r_state == ST_SOF || r_state == ST_BYTE || r_state == ST_ESC ||
                           r_state == ST_CKS || r_state == ST_EOF);
        s_ready = !rst && (r_state == ST_IDLE || r_state == ST_WAIT);
        busy    = !rst && (r_state != ST_IDLE);
    end

endmodule
